// File: rtl/muxn_arb_pkg.sv
// Shared constants for muxn_arb: mode encodings and legal parameter limits.
// Round-robin support is compiled in only when MUXN_ARB_RR_EN is defined.
package muxn_arb_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int NUM_IN_MIN = 32'd2;
    localparam int NUM_IN_MAX = 32'd16;
    localparam int W_MIN      = 32'd1;

endpackage

// File: rtl/muxn_arb_rr_arb.sv
// Combinational rotating-priority arbiter: first requester at or above ptr wins,
// wrapping by explicit compare so NUM_IN need not be a power of two.
module rr_arb
    import muxn_arb_pkg::*;
#(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req,
    input  logic [$clog2(NUM_IN)-1:0] ptr,
    output logic [NUM_IN-1:0]         gnt,
    output logic [$clog2(NUM_IN)-1:0] idx
);

    localparam int SW = $clog2(NUM_IN);
    localparam logic [SW:0] NUM_IN_L = (SW+1)'(NUM_IN);

    logic [SW:0]   sum_s;
    logic [SW-1:0] cand_s;
    logic          found_s;

    // Scan NUM_IN positions starting at ptr; the first requester wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum_s = {1'b0, ptr} + (SW+1)'(k);
            if (sum_s >= NUM_IN_L) begin
                sum_s = sum_s - NUM_IN_L;
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[SW-1:0];
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/muxn_arb.sv
// N-input registered mux with valid/ready on every port; direct select or
// round-robin arbitration (round-robin only when MUXN_ARB_RR_EN is defined).
module muxn_arb
    import muxn_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int W      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN*W-1:0]       in_data,
    input  logic [NUM_IN-1:0]         in_val,
    output logic [NUM_IN-1:0]         in_rdy,
    input  logic [$clog2(NUM_IN)-1:0] sel,
    input  logic                      mode,
    output logic [W-1:0]              out_data,
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [$clog2(NUM_IN)-1:0] grant
);

    localparam int SW = $clog2(NUM_IN);
    localparam logic [SW:0] NUM_IN_L = (SW+1)'(NUM_IN);

    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX || W < W_MIN) begin : g_bad_cfg
        $error("muxn_arb: NUM_IN or W outside legal range");
    end

    logic              can_accept_s;
    logic              pick_s;
    logic              xfer_s;
    logic [SW-1:0]     chosen_s;
    logic [NUM_IN-1:0] rdy_s;
    logic [W-1:0]      word_s;
    logic [W-1:0]      out_data_r;
    logic              out_val_r;
    logic [SW-1:0]     grant_r;

    // A fill is allowed when the register is empty or drains this same edge.
    assign can_accept_s = !out_val_r || out_rdy;

`ifdef MUXN_ARB_RR_EN
    localparam logic [SW-1:0] LAST_IDX = SW'(NUM_IN - 1);
    localparam logic [SW-1:0] ONE_IDX  = SW'(1);

    logic [SW-1:0]     ptr_r;
    logic [NUM_IN-1:0] rr_gnt_s;
    logic [SW-1:0]     rr_idx_s;
    logic              rr_mode_s;

    assign rr_mode_s = (mode == MODE_RR);

    rr_arb #(.NUM_IN(NUM_IN)) u_rr_arb (
        .req (in_val),
        .ptr (ptr_r),
        .gnt (rr_gnt_s),
        .idx (rr_idx_s)
    );
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;
`endif

    // Channel choice: arbiter winner in round-robin mode, else sel when in range.
    always_comb begin
        chosen_s = sel;
        pick_s   = 1'b0;
`ifdef MUXN_ARB_RR_EN
        if (rr_mode_s) begin
            chosen_s = rr_idx_s;
            pick_s   = |rr_gnt_s;
        end else begin
            pick_s = ({1'b0, sel} < NUM_IN_L);
        end
`else
        pick_s = ({1'b0, sel} < NUM_IN_L);
`endif
    end

    // One-hot ready and the matching data word; all ready bits low during reset.
    always_comb begin
        rdy_s  = '0;
        word_s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (reset && pick_s && can_accept_s && (chosen_s == SW'(i))) begin
                rdy_s[i] = 1'b1;
                word_s   = in_data[i*W +: W];
            end else begin
                rdy_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s = |(in_val & rdy_s);

    // Output register: fill on transfer, clear valid on a drain without refill.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_r <= '0;
            out_val_r  <= 1'b0;
            grant_r    <= '0;
        end else if (xfer_s) begin
            out_data_r <= word_s;
            out_val_r  <= 1'b1;
            grant_r    <= chosen_s;
        end else if (out_rdy) begin
            out_val_r  <= 1'b0;
        end else begin
            out_val_r  <= out_val_r;
        end
    end

`ifdef MUXN_ARB_RR_EN
    // Pointer moves past the winner only on a round-robin transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (rr_mode_s && xfer_s) begin
            ptr_r <= (chosen_s == LAST_IDX) ? '0 : chosen_s + ONE_IDX;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    assign in_rdy   = rdy_s;
    assign out_data = out_data_r;
    assign out_val  = out_val_r;
    assign grant    = grant_r;

endmodule

// File: tb/tb_muxn_arb.sv
// Self-checking bench for muxn_arb: directed scenarios plus a randomized run,
// all compared against a behavioural model of the valid/ready/arbitration rules.
module tb_muxn_arb;

    localparam int N = 4;
    localparam int W = 4;
`ifdef MUXN_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_val;
    logic [N-1:0]   in_rdy;
    logic [1:0]     sel;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_val;
    logic           out_rdy;
    logic [1:0]     grant;

    logic [11:0]    in_data3;
    logic [2:0]     in_val3;
    logic [2:0]     in_rdy3;
    logic [1:0]     sel3;
    logic           mode3;
    logic [W-1:0]   out_data3;
    logic           out_val3;
    logic           out_rdy3;
    logic [1:0]     grant3;

    muxn_arb #(.NUM_IN(N), .W(W)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
        .sel(sel), .mode(mode), .out_data(out_data), .out_val(out_val),
        .out_rdy(out_rdy), .grant(grant)
    );

    muxn_arb #(.NUM_IN(3), .W(W)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_val(in_val3), .in_rdy(in_rdy3),
        .sel(sel3), .mode(mode3), .out_data(out_data3), .out_val(out_val3),
        .out_rdy(out_rdy3), .grant(grant3)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_data;
    logic         m_val;
    int           m_grant;
    int           m_ptr;

    int fair_seq [6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected ready vector from the rules, using the model's register contents.
    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        r = '0;
        if (reset && (!m_val || out_rdy)) begin
            if (RR_EN && mode) begin
                for (int k = 0; k < N; k++) begin
                    int c = (m_ptr + k) % N;
                    if (in_val[c]) begin
                        r[c] = 1'b1;
                        break;
                    end
                end
            end else if (sel < N) begin
                r[sel] = 1'b1;
            end
        end
        return r;
    endfunction

    // Check everything mid-cycle, advance the model, step past the next edge.
    task automatic cycle();
        logic [N-1:0] r;
        int c;
        c = 0;
        @(negedge clk);
        r = exp_rdy();
        chk("in_rdy", in_rdy, r);
        chk("out_data", out_data, m_data);
        chk("out_val", out_val, m_val);
        chk("grant", grant, m_grant);
        if (!reset) begin
            m_data = '0; m_val = 1'b0; m_grant = 0; m_ptr = 0;
        end else if (|(in_val & r)) begin
            for (int i = 0; i < N; i++) if (r[i]) c = i;
            m_data  = in_data[c*W +: W];
            m_grant = c;
            m_val   = 1'b1;
            if (RR_EN && mode) m_ptr = (c + 1) % N;
        end else if (out_rdy) begin
            m_val = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset = 1'b0; in_val = 4'b1111; in_data = 16'h0000; sel = 2'd0; mode = 1'b0; out_rdy = 1'b1;
        in_data3 = 12'hABC; in_val3 = 3'b111; sel3 = 2'd3; mode3 = 1'b0; out_rdy3 = 1'b1;
        @(posedge clk);
        #1;
        m_data = '0; m_val = 1'b0; m_grant = 0; m_ptr = 0;

        // Reset held with all channels valid
        cycle();
        cycle();
        chk("rst_out_val", out_val, 1'b0);
        chk("rst_out_data", out_data, 4'h0);
        chk("rst_grant", grant, 2'd0);
        chk("rst_in_rdy", in_rdy, 4'b0000);
        chk("rst_out_val3", out_val3, 1'b0);

        // Direct select of channel 2; 3-input instance with out-of-range sel
        reset = 1'b1; mode = 1'b0; sel = 2'd2; in_val = 4'b0100; in_data = 16'h0B00; out_rdy = 1'b1;
        #1;
        chk("dir_in_rdy", in_rdy, 4'b0100);
        chk("oor_in_rdy3", in_rdy3, 3'b000);
        cycle();
        chk("dir_out_data", out_data, 4'hB);
        chk("dir_out_val", out_val, 1'b1);
        chk("dir_grant", grant, 2'd2);
        chk("oor_no_xfer3", out_val3, 1'b0);

        // Backpressure holds the word, then drain and refill share one edge
        out_rdy = 1'b0; in_data = 16'h0600;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_in_rdy", in_rdy, 4'b0000);
            cycle();
            chk("bp_hold", out_data, 4'hB);
        end
        out_rdy = 1'b1;
        #1;
        chk("refill_rdy", in_rdy, 4'b0100);
        cycle();
        chk("refill_data", out_data, 4'h6);
        chk("refill_val", out_val, 1'b1);

        // Round-robin fairness with all channels requesting
        mode = 1'b1; in_val = 4'b1111; in_data = 16'h4321;
        for (int j = 0; j < 6; j++) begin
            cycle();
            chk("rr_fair", grant, RR_EN ? fair_seq[j] : 2);
        end

        // Skip and wrap: move ptr to 3, then requests only on 0 and 1
        in_val = 4'b0100;
        cycle();
        chk("rr_to3", grant, 2'd2);
        in_val = 4'b0011;
        cycle();
        chk("rr_wrap0", grant, RR_EN ? 0 : 2);
        cycle();
        chk("rr_next1", grant, RR_EN ? 1 : 2);
        in_val = 4'b0001;
        cycle();
        chk("rr_wrap_again", grant, RR_EN ? 0 : 2);

        // Reset while a word is stuck in the output register
        in_val = 4'b0100; out_rdy = 1'b0;
        cycle();
        chk("mid_fill", out_val, 1'b1);
        cycle();
        reset = 1'b0;
        cycle();
        chk("mid_rst_val", out_val, 1'b0);
        chk("mid_rst_grant", grant, 2'd0);
        reset = 1'b1; mode = 1'b1; in_val = 4'b1111; out_rdy = 1'b1;
        cycle();
        chk("post_rst_rr", grant, RR_EN ? 0 : 2);

        // Randomized traffic against the model
        for (int t = 0; t < 200; t++) begin
            reset   = ($urandom_range(0, 39) != 0);
            mode    = 1'($urandom_range(0, 1));
            sel     = 2'($urandom_range(0, 3));
            in_val  = 4'($urandom_range(0, 15));
            in_data = 16'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-input, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the sequential successor to the 2:1 4-bit gate-level mux. It selects one of NUM_IN channels, either by an external select or by a rotating round-robin arbiter, and holds the chosen word in a one-entry output register. It sits between multiple producers (for example, register-file or memory response paths) and a single consumer in the datapath.

## Interface
- NUM_IN, 4: number of input channels; legal range 2..16.
- W, 4: data width per channel; legal range ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- in_data  in  NUM_IN*W  packed channel data; channel i occupies bits [i*W +: W].
- in_val  in  NUM_IN  per-channel valid.
- in_rdy  out  NUM_IN  per-channel ready; at most one bit is high per cycle.
- sel  in  $clog2(NUM_IN)  channel index used in direct mode.
- mode  in  1  0 = direct (use sel), 1 = round-robin.
- out_data  out  W  registered data.
- out_val  out  1  output register holds a valid word.
- out_rdy  in  1  consumer ready.
- grant  out  $clog2(NUM_IN)  index of the channel whose word is in the output register.

## Operation
- can_accept = !out_val | out_rdy. This gives full throughput when a drain and a fill happen in the same cycle.
- Direct mode:
  - in_rdy[sel] = can_accept; all other in_rdy bits are 0.
  - If sel ≥ NUM_IN, all in_rdy bits are 0 and no transfer occurs.
- Round-robin mode:
  - The winner is the first i with in_val[i]=1, searching from ptr upward and wrapping from NUM_IN-1 to 0.
  - in_rdy[winner] = can_accept; all other bits are 0.
  - If no in_val bit is set, all in_rdy bits are 0.
- Transfer occurs when in_val[c] & in_rdy[c]. On a transfer:
  - out_data ← channel c data, grant ← c, out_val ← 1.
  - In round-robin mode, ptr ← (c+1) mod NUM_IN. The wrap uses explicit compare, not power-of-two masking, so NUM_IN need not be a power of two.
- Drain without fill (out_val & out_rdy, no transfer): out_val ← 0. out_data and grant hold their last values.
- No drain and out_val=1: out_data, grant and out_val hold. in_rdy is all zeros.
- ptr is held while in direct mode and while no transfer occurs.
- A mode change takes effect in the same cycle it is applied (combinational select path). ptr is not reset by a mode change.
- Reset has priority over all other events, including mid-transfer. Reset values: out_val=0, out_data=0, grant=0, ptr=0. in_rdy is all zeros while reset=0.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on out_data/out_val after edge k.
- Throughput is 1 word per cycle while out_rdy=1.
- in_rdy is combinational from out_val, out_rdy, mode, sel and (in round-robin mode) in_val.
  - Producers must not make in_val depend on in_rdy.
  - out_rdy must not depend on in_rdy.
- out_data, out_val and grant come straight from flops, with no combinational path from any input.
- A producer must hold in_val and in_data stable until its transfer occurs.

## Configuration
- MUXN_ARB_RR_EN defined: round-robin mode, the ptr register and the arbiter are compiled in. mode behaves as above.
- MUXN_ARB_RR_EN undefined: the mode port remains but is ignored. The block always operates in direct mode, and no ptr register is synthesised.

## Structure
- Shared package muxn_arb_pkg holds:
  - the mode constants MODE_DIRECT=1'b0 and MODE_RR=1'b1;
  - the NUM_IN and W limit constants used by elaboration-time assertions.
- Sub-module rr_arb: a combinational rotating-priority arbiter.
  - Inputs: req[NUM_IN], ptr.
  - Outputs: one-hot gnt and the binary index of the winner.
  - Instantiated only under MUXN_ARB_RR_EN.
- Top level: select logic, output register, ptr register.

## Test plan
All scenarios use NUM_IN=4, W=4.
- Reset: hold reset=0 for 2 cycles with all in_val=1 → out_val=0, out_data=0000, grant=0, in_rdy=0000. After release, in_rdy is non-zero on the first cycle.
- Direct mode: mode=0, sel=2, in_data ch2=1011, in_val=0100, out_rdy=1 → in_rdy=0100, and the next cycle shows out_data=1011, out_val=1, grant=2. Set sel=5 is impossible at this width, so instead test NUM_IN=3 with sel=3 → in_rdy=000 and no transfer.
- Backpressure: out_rdy=0 after a fill → in_rdy=0000 and out_data is held for 3 cycles. Raise out_rdy with a new word pending → drain and refill occur in the same edge, with no bubble.
- Round-robin fairness: mode=1, in_val=1111 continuously, out_rdy=1 → grant sequence 0,1,2,3,0,1.
- Round-robin skip and wrap: ptr=3, in_val=0011 → winner 0, then winner 1, then (in_val=0001) winner 0.
- Mid-transfer reset: assert reset=0 while out_val=1 and out_rdy=0 → next cycle out_val=0, ptr=0. The next round-robin grant is channel 0.
- Randomised: random data, valids, sel, mode and out_rdy for 200 cycles, checked against a reference model with an arbiter pointer.
